// File: rtl/multiaddr_encode.sv
// ---------------------------------------------------------------------------
// multiaddr_encode
//
// Purpose:
//   Turns one request (base address, don't-care mask, target bitmask) into a
//   short sequence of {addr, mask} multi-address beats. Each beat covers an
//   aligned power-of-two block of consecutive selected targets. The target
//   index lives in addr[StrideLog2 +: IdxWidth]; a beat's mask sets the low
//   k bits of that field so a decoder matches 2^k targets at once. Beats are
//   emitted lowest index first, one per cycle while the consumer is ready.
//
// Parameters:
//   NumTargets - number of targets (power of two, >= 2)
//   StrideLog2 - log2 of the address distance between consecutive targets
//   addr_t     - address / mask type; must be wide enough to hold the index
//                field at StrideLog2
//
// Ports:
//   clk_i       in   clock
//   rst_i       in   synchronous active-high reset
//   in_valid_i  in   request valid
//   in_ready_o  out  request ready (high only while idle)
//   addr_i      in   base address (index-field bits ignored)
//   mask_i      in   don't-care bits outside the index field (index bits ignored)
//   targets_i   in   target selection bitmask
//   out_valid_o out  beat valid
//   out_ready_i in   beat ready
//   addr_o      out  beat address (index field = first covered target)
//   mask_o      out  beat mask (index field = block size - 1)
//   last_o      out  final beat of the current request
// ---------------------------------------------------------------------------
module multiaddr_encode #(
    parameter int unsigned NumTargets = 32'd8,
    parameter int unsigned StrideLog2 = 32'd16,
    parameter type         addr_t     = logic [31:0]
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  addr_t                 addr_i,
    input  addr_t                 mask_i,
    input  logic [NumTargets-1:0] targets_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output addr_t                 addr_o,
    output addr_t                 mask_o,
    output logic                  last_o
);

    // Width of the target index field; derived, not meant to be overridden.
    localparam int unsigned IdxWidth = (NumTargets > 1) ? $clog2(NumTargets) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_e;

    state_e                state_q, state_d;
    addr_t                 addr_q, addr_d;
    addr_t                 mask_q, mask_d;
    logic [NumTargets-1:0] rem_q, rem_d;

    // Per-beat combinational results derived from rem_q.
    logic [IdxWidth-1:0]   low_idx;
    int                    low_int;
    logic                  low_found;
    logic [IdxWidth-1:0]   blk_span;
    logic [NumTargets-1:0] blk_bits;
    logic [NumTargets-1:0] cand_bits;
    logic [NumTargets-1:0] rem_after;
    logic                  beat_last;
    addr_t                 addr_beat;
    addr_t                 mask_beat;
    logic                  out_hs;

    // Find the lowest still-pending target; it starts the next beat.
    always_comb begin
        low_idx   = '0;
        low_int   = 0;
        low_found = 1'b0;
        for (int j = 0; j < int'(NumTargets); j++) begin
            if (!low_found && rem_q[j]) begin
                low_idx   = IdxWidth'(j);
                low_int   = j;
                low_found = 1'b1;
            end
        end
    end

    // Grow the block from the lowest pending target as far as it stays
    // aligned, inside the target range and fully selected. All three
    // conditions only get harder as the block grows, so the last size that
    // passes is the largest one.
    always_comb begin
        blk_span  = '0;
        blk_bits  = '0;
        cand_bits = '0;
        if (low_found) begin
            blk_bits[low_idx] = 1'b1;
        end
        for (int k = 1; k <= int'(IdxWidth); k++) begin
            cand_bits = '0;
            for (int j = 0; j < int'(NumTargets); j++) begin
                cand_bits[j] = (j >= low_int) && (j < low_int + (1 << k));
            end
            if (low_found
                && ((low_int % (1 << k)) == 0)
                && ((low_int + (1 << k)) <= int'(NumTargets))
                && ((rem_q & cand_bits) == cand_bits)) begin
                blk_span = IdxWidth'((1 << k) - 1);
                blk_bits = cand_bits;
            end
        end
    end

    // Splice the block start and block size into the stored address and mask.
    always_comb begin
        addr_beat = addr_q;
        mask_beat = mask_q;
        addr_beat[StrideLog2 +: IdxWidth] = low_idx;
        mask_beat[StrideLog2 +: IdxWidth] = blk_span;
        rem_after = rem_q & ~blk_bits;
        beat_last = (rem_after == '0);
    end

    assign out_valid_o = (state_q == EMIT);
    assign in_ready_o  = (state_q == IDLE);
    assign out_hs      = out_valid_o && out_ready_i;

    // Outputs are forced to zero while idle so nothing stale leaks out after
    // reset or between requests; during EMIT they depend only on registers,
    // so they hold still across a stall.
    assign addr_o = out_valid_o ? addr_beat : '0;
    assign mask_o = out_valid_o ? mask_beat : '0;
    assign last_o = out_valid_o && beat_last;

    // Next-state logic. An all-zero target set is consumed in place without
    // leaving IDLE.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        mask_d  = mask_q;
        rem_d   = rem_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid_i) begin
                    addr_d = addr_i;
                    mask_d = mask_i;
                    rem_d  = targets_i;
                    if (targets_i != '0) begin
                        state_d = EMIT;
                    end
                end
            end
            EMIT: begin
                if (out_hs) begin
                    rem_d = rem_after;
                    if (beat_last) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and request registers; reset drops any request in flight and
    // takes priority over an input offered in the same cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            addr_q  <= '0;
            mask_q  <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            mask_q  <= mask_d;
            rem_q   <= rem_d;
        end
    end

endmodule

// File: tb/tb_multiaddr_encode.sv
// ---------------------------------------------------------------------------
// tb_multiaddr_encode
//
// Purpose:
//   Self-checking bench for multiaddr_encode with NumTargets=8,
//   StrideLog2=16 and 32-bit addresses. Expected beats come from a
//   behavioural model that splits the target set greedily into aligned
//   power-of-two blocks. Inputs are driven and outputs sampled on the
//   falling clock edge.
// ---------------------------------------------------------------------------
module tb_multiaddr_encode;

    localparam logic [31:0] FieldMask = 32'h0007_0000;

    logic        clk_i;
    logic        rst_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] addr_i;
    logic [31:0] mask_i;
    logic [7:0]  targets_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] addr_o;
    logic [31:0] mask_o;
    logic        last_o;

    int checks;
    int errors;

    logic [31:0] exp_addr[$];
    logic [31:0] exp_mask[$];
    logic        exp_last[$];

    multiaddr_encode #(
        .NumTargets(32'd8),
        .StrideLog2(32'd16),
        .addr_t    (logic [31:0])
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .in_valid_i (in_valid_i),
        .in_ready_o (in_ready_o),
        .addr_i     (addr_i),
        .mask_i     (mask_i),
        .targets_i  (targets_i),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i),
        .addr_o     (addr_o),
        .mask_o     (mask_o),
        .last_o     (last_o)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // Single comparison point: counts every check, reports and counts misses.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Reference model: repeatedly take the lowest pending target and double
    // the block while it stays aligned, inside 8 targets and fully selected.
    task automatic buildModel(input logic [31:0] a, input logic [31:0] m,
                              input logic [7:0] t);
        int r;
        int i;
        int sz;
        int want;
        exp_addr.delete();
        exp_mask.delete();
        exp_last.delete();
        r = int'(t);
        while (r != 0) begin
            i = 0;
            while (((r >> i) & 1) == 0) i++;
            sz = 1;
            forever begin
                want = (1 << (2 * sz)) - 1;
                if ((i % (2 * sz)) == 0 && (i + 2 * sz) <= 8 && ((r >> i) & want) == want)
                    sz = 2 * sz;
                else
                    break;
            end
            r = r & ~(((1 << sz) - 1) << i);
            exp_addr.push_back((a & ~FieldMask) | (32'(i) << 16));
            exp_mask.push_back((m & ~FieldMask) | (32'(sz - 1) << 16));
            exp_last.push_back(r == 0);
        end
    endtask

    // Offer one request and follow its beats cycle by cycle.
    // mode: 0 = always ready, 1 = random back-pressure, 2 = ready low for
    // three cycles on the second beat. reset_after > 0 asserts reset right
    // after that many beats have been taken.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] m,
                                 input logic [7:0] t, input int mode,
                                 input int reset_after);
        int  beat;
        int  cycles;
        int  stall_left;
        bit  stalled_once;
        logic rdy;
        buildModel(a, m, t);
        checkOutput("in_ready_idle", 32'(in_ready_o), 32'd1);
        in_valid_i  = 1'b1;
        addr_i      = a;
        mask_i      = m;
        targets_i   = t;
        out_ready_i = 1'b0;
        @(negedge clk_i);
        in_valid_i = 1'b0;
        addr_i     = $urandom;
        mask_i     = $urandom;
        targets_i  = 8'($urandom);
        beat = 0;
        cycles = 0;
        stall_left = 0;
        stalled_once = 1'b0;
        while (beat < exp_addr.size() && cycles < 200) begin
            checkOutput("out_valid", 32'(out_valid_o), 32'd1);
            checkOutput("in_ready_busy", 32'(in_ready_o), 32'd0);
            checkOutput("addr_o", addr_o, exp_addr[beat]);
            checkOutput("mask_o", mask_o, exp_mask[beat]);
            checkOutput("last_o", 32'(last_o), 32'(exp_last[beat]));
            rdy = 1'b1;
            if (mode == 1) begin
                rdy = ($urandom_range(0, 3) != 0);
            end else if (mode == 2) begin
                if (beat == 1 && !stalled_once) begin
                    stalled_once = 1'b1;
                    stall_left = 3;
                end
                if (stall_left > 0) begin
                    rdy = 1'b0;
                    stall_left--;
                end
            end
            out_ready_i = rdy;
            @(negedge clk_i);
            cycles++;
            if (rdy) begin
                beat++;
                if (beat == reset_after) begin
                    rst_i       = 1'b1;
                    in_valid_i  = 1'b1;
                    targets_i   = 8'hFF;
                    out_ready_i = 1'b1;
                    @(negedge clk_i);
                    rst_i      = 1'b0;
                    in_valid_i = 1'b0;
                    out_ready_i = 1'b0;
                    checkOutput("rst_out_valid", 32'(out_valid_o), 32'd0);
                    checkOutput("rst_in_ready", 32'(in_ready_o), 32'd1);
                    checkOutput("rst_addr_o", addr_o, 32'd0);
                    checkOutput("rst_mask_o", mask_o, 32'd0);
                    checkOutput("rst_last_o", 32'(last_o), 32'd0);
                    @(negedge clk_i);
                    checkOutput("rst_input_dropped", 32'(out_valid_o), 32'd0);
                    return;
                end
            end
        end
        checkOutput("beat_count", 32'(beat), 32'(exp_addr.size()));
        if (mode == 0) begin
            checkOutput("throughput", 32'(cycles), 32'(exp_addr.size()));
        end
        checkOutput("done_out_valid", 32'(out_valid_o), 32'd0);
        checkOutput("done_in_ready", 32'(in_ready_o), 32'd1);
        out_ready_i = 1'b0;
    endtask

    // Directed scenarios first, then randomized requests with back-pressure.
    initial begin
        checks      = 0;
        errors      = 0;
        rst_i       = 1'b1;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b0;
        addr_i      = '0;
        mask_i      = '0;
        targets_i   = '0;
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        checkOutput("reset_out_valid", 32'(out_valid_o), 32'd0);
        checkOutput("reset_in_ready", 32'(in_ready_o), 32'd1);
        checkOutput("reset_addr_o", addr_o, 32'd0);
        checkOutput("reset_mask_o", mask_o, 32'd0);
        checkOutput("reset_last_o", 32'(last_o), 32'd0);

        applyStimulus(32'h8003_1234, 32'h0000_0000, 8'hFF, 0, 0);
        applyStimulus(32'h8000_0000, 32'h0000_0000, 8'h6E, 0, 0);
        applyStimulus(32'h8000_0000, 32'h0000_00FF, 8'h0F, 0, 0);
        applyStimulus(32'h8000_0000, 32'h0000_0000, 8'h6E, 2, 0);
        applyStimulus(32'h8000_0000, 32'h0000_0000, 8'h00, 0, 0);
        applyStimulus(32'h8000_0000, 32'h0000_0000, 8'h6E, 0, 1);
        applyStimulus(32'h8000_0000, 32'h0000_0000, 8'h80, 0, 0);

        for (int n = 0; n < 40; n++) begin
            applyStimulus($urandom, $urandom, 8'($urandom), (n % 2), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
